// File: rtl/garage_pkg.sv
// garage_pkg: shared state encoding, default capacity and lane ids for the garage gate logic
package garage_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        OPENING = 3'd1,
        PASS    = 3'd2,
        CLOSING = 3'd3,
        FAULT   = 3'd4
    } gate_state_t;
    localparam int   DEF_CAPACITY = 50;
    localparam logic LANE_ENTRY   = 1'b0;
    localparam logic LANE_EXIT    = 1'b1;
endpackage

// File: rtl/garage_gate_arbiter_if.sv
// garage_gate_arbiter_if: lane sensors, barrier motor and lot-status signals of the gate
//   master: drives entry_req, exit_req, car_passed, lim_open, lim_closed
//   slave : drives motor_open, motor_close, entry_grant, exit_grant, count, full, empty, fault
interface garage_gate_arbiter_if #(parameter int CNT_W = 6);
    logic             entry_req, exit_req, car_passed, lim_open, lim_closed;
    logic             motor_open, motor_close, entry_grant, exit_grant;
    logic             full, empty, fault;
    logic [CNT_W-1:0] count;
    modport master (
        output entry_req, exit_req, car_passed, lim_open, lim_closed,
        input  motor_open, motor_close, entry_grant, exit_grant, count, full, empty, fault
    );
    modport slave (
        input  entry_req, exit_req, car_passed, lim_open, lim_closed,
        output motor_open, motor_close, entry_grant, exit_grant, count, full, empty, fault
    );
endinterface

// File: rtl/garage_timeout_timer.sv
// garage_timeout_timer: cycle counter with clear, enable and terminal-count compare
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the count (takes priority over enable)
//   en         : count this cycle
//   limit      : terminal value
//   tc         : enabled and count==limit
module garage_timeout_timer #(parameter int W = 10) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk)
        if (reset || clear) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    assign tc = en && cnt == limit;
endmodule

// File: rtl/garage_gate_arbiter.sv
// garage_gate_arbiter: shares one barrier between entry and exit lanes, sequences the motor, counts cars
//   clk, reset : clock, synchronous active-high reset
//   bus.slave  : lane requests, car_passed, limit switches in; motor drives, grants,
//                occupancy count, full/empty and sticky fault out
module garage_gate_arbiter
    import garage_pkg::*;
#(
    parameter int CAPACITY = DEF_CAPACITY,
    parameter int CNT_W    = 6,
    parameter int PASS_TO  = 1000,
    parameter int MOTOR_TO = 500
) (
    input  logic                 clk,
    input  logic                 reset,
    garage_gate_arbiter_if.slave bus
);
    localparam int TMAX = PASS_TO > MOTOR_TO ? PASS_TO : MOTOR_TO;
    localparam int TW   = $clog2(TMAX);
    gate_state_t      state;
    logic [CNT_W-1:0] count_q;
    logic             ptr, eg, xg, mo, mc, flt;
    logic             full, empty, elig_e, elig_x, pick, leave, en, tc;
    logic [TW-1:0]    limit;
    assign full   = count_q == CNT_W'(CAPACITY);
    assign empty  = count_q == '0;
    assign elig_e = bus.entry_req && !full;
    assign elig_x = bus.exit_req && !empty;
    // Contention goes to the pointer's lane; a lone eligible lane always wins.
    assign pick   = (elig_e && elig_x) ? ptr : (elig_x ? LANE_EXIT : LANE_ENTRY);
    assign en     = state == OPENING || state == PASS || state == CLOSING;
    always_comb begin
        limit = state == PASS ? TW'(PASS_TO - 1) : TW'(MOTOR_TO - 1);
        leave = state == IDLE    ? (elig_e || elig_x) :
                state == OPENING ? (bus.lim_open || tc) :
                state == PASS    ? (bus.car_passed || tc) :
                state == CLOSING ? (bus.lim_closed || tc) : 1'b0;
    end
    // Timer restarts on every state change.
    garage_timeout_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (leave),
        .en    (en),
        .limit (limit),
        .tc    (tc)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count_q <= '0;
            ptr     <= LANE_ENTRY;
            eg      <= 1'b0;
            xg      <= 1'b0;
            mo      <= 1'b0;
            mc      <= 1'b0;
            flt     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (elig_e || elig_x) begin
                    state <= OPENING;
                    eg    <= pick == LANE_ENTRY;
                    xg    <= pick == LANE_EXIT;
                    mo    <= 1'b1;
                    ptr   <= ~ptr;
                end
                OPENING: if (bus.lim_open) begin
                    state <= PASS;
                    mo    <= 1'b0;
                end else if (tc) begin
                    state <= FAULT;
                    mo    <= 1'b0;
                    eg    <= 1'b0;
                    xg    <= 1'b0;
                    flt   <= 1'b1;
                end
                PASS: if (bus.car_passed || tc) begin
                    state <= CLOSING;
                    mc    <= 1'b1;
                    // Count saturates at both ends regardless of the pulse.
                    if (bus.car_passed && eg && !full) count_q <= count_q + 1'b1;
                    else if (bus.car_passed && xg && !empty) count_q <= count_q - 1'b1;
                end
                CLOSING: if (bus.lim_closed) begin
                    state <= IDLE;
                    mc    <= 1'b0;
                    eg    <= 1'b0;
                    xg    <= 1'b0;
                end else if (tc) begin
                    state <= FAULT;
                    mc    <= 1'b0;
                    eg    <= 1'b0;
                    xg    <= 1'b0;
                    flt   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
    assign bus.motor_open  = mo;
    assign bus.motor_close = mc;
    assign bus.entry_grant = eg;
    assign bus.exit_grant  = xg;
    assign bus.fault       = flt;
    assign bus.count       = count_q;
    assign bus.full        = full;
    assign bus.empty       = empty;
    a_motor_excl: assert property (@(posedge clk) !(mo && mc));
endmodule

// File: tb/tb_garage_gate_arbiter.sv
// tb_garage_gate_arbiter: directed and randomized lane transactions checked against a lot-level model
module tb_garage_gate_arbiter;
    localparam int CAP = 50;
    localparam int PT  = 1000;
    localparam int MT  = 500;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   m_count;
    bit   m_ptr;
    always #5 clk = ~clk;
    garage_gate_arbiter_if #(.CNT_W(6)) g ();
    garage_gate_arbiter #(.CAPACITY(CAP), .CNT_W(6), .PASS_TO(PT), .MOTOR_TO(MT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (g)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(negedge clk);
    endtask
    task automatic chk_idle(input string tag);
        chk({tag, "_eg"}, g.entry_grant, 0);
        chk({tag, "_xg"}, g.exit_grant, 0);
        chk({tag, "_mo"}, g.motor_open, 0);
        chk({tag, "_mc"}, g.motor_close, 0);
        chk({tag, "_cnt"}, g.count, m_count);
        chk({tag, "_full"}, g.full, m_count == CAP);
        chk({tag, "_empty"}, g.empty, m_count == 0);
    endtask
    task automatic do_reset();
        reset = 1'b1;
        g.entry_req = 0; g.exit_req = 0; g.car_passed = 0; g.lim_open = 0; g.lim_closed = 0;
        repeat (2) tick();
        reset = 1'b0;
        m_count = 0;
        m_ptr = 0;
    endtask
    // One full gate cycle from the lane's point of view; the model only tracks
    // the lot count and the contention pointer.
    task automatic txn(input bit er, input bit xr, input int od, input bit use_pass,
                       input int pd, input int cd, input bit noise);
        bit ee, ex, lane;
        ee = er && m_count != CAP;
        ex = xr && m_count != 0;
        g.entry_req = er;
        g.exit_req = xr;
        tick();
        g.entry_req = 0;
        g.exit_req = 0;
        if (!ee && !ex) begin
            chk("nogrant_eg", g.entry_grant, 0);
            chk("nogrant_xg", g.exit_grant, 0);
            chk("nogrant_mo", g.motor_open, 0);
            return;
        end
        lane = (ee && ex) ? m_ptr : ex;
        m_ptr = ~m_ptr;
        chk("grant_eg", g.entry_grant, lane == 0);
        chk("grant_xg", g.exit_grant, lane == 1);
        chk("open_mo", g.motor_open, 1);
        chk("open_mc", g.motor_close, 0);
        repeat (od) begin
            g.car_passed = noise && $urandom_range(0, 1) == 1;
            tick();
        end
        g.car_passed = 0;
        g.lim_open = 1;
        tick();
        g.lim_open = 0;
        chk("pass_mo", g.motor_open, 0);
        chk("pass_mc", g.motor_close, 0);
        chk("pass_cnt", g.count, m_count);
        if (use_pass) begin
            repeat (pd) tick();
            g.car_passed = 1;
            tick();
            g.car_passed = 0;
            if (lane == 0 && m_count < CAP) m_count++;
            if (lane == 1 && m_count > 0) m_count--;
        end else begin
            repeat (PT - 1) tick();
            chk("pass_hold_mc", g.motor_close, 0);
            tick();
        end
        chk("close_mc", g.motor_close, 1);
        chk("close_cnt", g.count, m_count);
        chk("close_eg", g.entry_grant, lane == 0);
        chk("close_xg", g.exit_grant, lane == 1);
        g.entry_req = noise && lane == 0;
        g.exit_req = noise && lane == 1;
        repeat (cd) begin
            g.car_passed = noise && $urandom_range(0, 1) == 1;
            tick();
            chk("close_hold_mc", g.motor_close, 1);
            chk("close_hold_mo", g.motor_open, 0);
        end
        g.car_passed = 0;
        g.entry_req = 0;
        g.exit_req = 0;
        g.lim_closed = 1;
        tick();
        g.lim_closed = 0;
        chk_idle("closed");
    endtask
    initial begin
        do_reset();
        chk_idle("reset");
        chk("reset_fault", g.fault, 0);
        // Single entry car
        txn(1, 0, 3, 1, 2, 2, 0);
        chk("t1_cnt", g.count, 1);
        // Contention alternation at count 10
        do_reset();
        for (int i = 0; i < 10; i++) txn(1, 0, 1, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) txn(1, 1, 1, 1, 0, 1, 0);
        chk("t2_cnt", g.count, 10);
        // Fill to capacity, blocked entry, then one exit
        for (int i = 0; i < 40; i++) txn(1, 0, 0, 1, 0, 0, 0);
        chk("t3_full", g.full, 1);
        txn(1, 0, 0, 1, 0, 0, 0);
        txn(0, 1, 0, 1, 0, 0, 0);
        chk("t3_cnt", g.count, 49);
        chk("t3_notfull", g.full, 0);
        // Exit on empty lot, then pass timeout
        do_reset();
        txn(0, 1, 0, 1, 0, 0, 0);
        txn(1, 0, 2, 0, 0, 1, 0);
        chk("t4_cnt", g.count, 0);
        // Opening timeout into fault
        do_reset();
        g.entry_req = 1;
        tick();
        g.entry_req = 0;
        chk("t5_grant", g.entry_grant, 1);
        repeat (MT - 1) tick();
        chk("t5_prefault", g.fault, 0);
        chk("t5_premo", g.motor_open, 1);
        tick();
        chk("t5_fault", g.fault, 1);
        chk("t5_mo", g.motor_open, 0);
        chk("t5_mc", g.motor_close, 0);
        chk("t5_eg", g.entry_grant, 0);
        g.entry_req = 1; g.lim_open = 1; g.lim_closed = 1;
        repeat (5) tick();
        chk("t5_sticky", g.fault, 1);
        chk("t5_stuck_eg", g.entry_grant, 0);
        do_reset();
        chk("t5_clr", g.fault, 0);
        chk_idle("t5_rst");
        // Reset in PASS with five cars inside
        for (int i = 0; i < 5; i++) txn(1, 0, 0, 1, 0, 0, 0);
        chk("t6_cnt5", g.count, 5);
        g.entry_req = 1;
        tick();
        g.entry_req = 0;
        g.lim_open = 1;
        tick();
        g.lim_open = 0;
        reset = 1;
        tick();
        reset = 0;
        m_count = 0;
        m_ptr = 0;
        chk_idle("t6_rst");
        chk("t6_fault", g.fault, 0);
        g.car_passed = 1;
        tick();
        g.car_passed = 0;
        tick();
        chk("t6_idle_pulse", g.count, 0);
        // Randomized traffic
        do_reset();
        repeat (60)
            txn($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 6),
                $urandom_range(0, 15) != 0, $urandom_range(0, 6), $urandom_range(0, 6), 1);
        chk("rand_fault", g.fault, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
